// File: rtl/wts_channel_mixer_5ch.sv
// Five-channel wave sample mixer: scales each time-multiplexed channel sample by its
// volume, accumulates slots 0..4 in order and emits one floor(sum/16) frame sample.
module wts_channel_mixer_5ch (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [2:0]         sample_slot,
  input  logic signed [7:0]  sample_in,
  input  logic [3:0]         reg_volume,
  input  logic               reg_enable,
  output logic signed [10:0] mix_out,
  output logic               mix_valid,
  output logic               seq_error
);

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 4;
  localparam int PROD_W    = 12;
  localparam int ACC_W     = 15;
  localparam int MIX_W     = 11;
  localparam int MIX_SHIFT = 4;
  localparam logic [2:0] LAST_SLOT = 3'd4;

  // Volume is unsigned, so it is zero-extended before the signed multiply.
  function automatic logic signed [PROD_W-1:0] scale_sample(
    input logic signed [DATA_W-1:0] smp,
    input logic        [COEF_W-1:0] vol,
    input logic                     en
  );
    logic signed [PROD_W-1:0] smp_ext;
    logic signed [PROD_W-1:0] vol_ext;
    smp_ext = PROD_W'(smp);
    vol_ext = $signed(PROD_W'(vol));
    scale_sample = en ? smp_ext * vol_ext : '0;
  endfunction

  // Arithmetic shift floors; the worst-case frame sum keeps the result inside 11 bits.
  function automatic logic signed [MIX_W-1:0] scale_frame(
    input logic signed [ACC_W-1:0] sum
  );
    logic signed [ACC_W-1:0] shifted;
    shifted     = sum >>> MIX_SHIFT;
    scale_frame = shifted[MIX_W-1:0];
  endfunction

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic                     vld_p0;
  logic                     slot_first_p0;
  logic                     slot_match_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic [2:0]               exp_slot_p1;

  // Stage p0: product and running sum for the sample presented this cycle.
  always_comb begin
    prod_p0       = scale_sample(sample_in, reg_volume, reg_enable);
    sum_p0        = acc_p1 + ACC_W'(prod_p0);
    vld_p0        = sample_valid && (sample_slot <= LAST_SLOT);
    slot_first_p0 = (sample_slot == 3'd0);
    slot_match_p0 = (sample_slot == exp_slot_p1);
  end

  // Stage p1: frame accumulator, slot tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1      <= '0;
      exp_slot_p1 <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      seq_error <= 1'b0;
      if (vld_p0) begin
        if (slot_first_p0) begin
          // Slot 0 always restarts a frame, dropping any partial one silently.
          acc_p1      <= ACC_W'(prod_p0);
          exp_slot_p1 <= 3'd1;
        end else if (slot_match_p0 && exp_slot_p1 == LAST_SLOT) begin
          mix_out     <= scale_frame(sum_p0);
          mix_valid   <= 1'b1;
          acc_p1      <= '0;
          exp_slot_p1 <= '0;
        end else if (slot_match_p0) begin
          acc_p1      <= sum_p0;
          exp_slot_p1 <= exp_slot_p1 + 3'd1;
        end else begin
          seq_error   <= 1'b1;
          acc_p1      <= '0;
          exp_slot_p1 <= '0;
        end
      end
    end
  end

endmodule
